// File: rtl/data_mem_mmio.sv
// Data-side memory for the multi-cycle core: byte-enabled word RAM plus an MMIO window
// holding a cycle counter, console TX FIFO with valid/ready drain, status and sticky halt.
module data_mem_mmio #(
   parameter int          MEM_WORDS  = 16384,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_read,
   input  logic [3:0]  data_write,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halt
);

   localparam int          AW        = $clog2(MEM_WORDS);
   localparam int          PW        = $clog2(FIFO_DEPTH);
   localparam int          CW        = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

   logic [31:0]   mem [MEM_WORDS];
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          ovf;
   logic [31:0]   cycle_cnt;

   logic          ram_hit, mmio_hit, any_wr;
   logic [AW-1:0] ram_idx;
   logic [1:0]    off;
   logic          full, empty, pop, push_req, push, status_wr, halt_set;
   logic [31:0]   status_word, mmio_word, rd_word;
   logic          unused_addr_bits;

   assign ram_hit          = data_addr < RAM_BYTES;
   assign mmio_hit         = data_addr[31:4] == MMIO_BASE[31:4];
   assign ram_idx          = data_addr[AW+1:2];
   assign off              = data_addr[3:2];
   assign any_wr           = |data_write;
   assign unused_addr_bits = ^data_addr[1:0];

   assign full      = count == CW'(FIFO_DEPTH);
   assign empty     = count == '0;
   assign tx_valid  = !empty;
   assign tx_data   = fifo_mem[rptr];
   assign pop       = tx_valid & tx_ready;
   assign push_req  = mmio_hit && (off == 2'd1) && data_write[0];
   // a full FIFO still accepts a push when the head leaves on the same edge
   assign push      = push_req && (!full || pop);
   assign status_wr = mmio_hit && (off == 2'd2) && any_wr;
   assign halt_set  = mmio_hit && (off == 2'd3) && any_wr && (data_in != '0);

   assign status_word = {26'b0, 3'(count), ovf, empty, full};

   always_ff @(posedge clk) begin
      if (ram_hit) begin
         for (int i = 0; i < 4; i++) begin
            if (data_write[i]) mem[ram_idx][8*i +: 8] <= data_in[8*i +: 8];
         end
      end
   end

   always_comb begin
      mmio_word = '0;
      rd_word   = '0;
      case (off)
         2'd0:    mmio_word = cycle_cnt;
         2'd1:    mmio_word = '0;
         2'd2:    mmio_word = status_word;
         default: mmio_word = {31'b0, halt};
      endcase
      if (ram_hit)       rd_word = mem[ram_idx];
      else if (mmio_hit) rd_word = mmio_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           data_out <= '0;
      else if (data_read) data_out <= rd_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         if (push) begin
            fifo_mem[wptr] <= data_in[7:0];
            wptr           <= wptr + 1'b1;
         end
         if (pop) rptr <= rptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (push_req && full && !pop) ovf <= 1'b1;
         else if (status_wr)           ovf <= 1'b0;
      end
   end

   // counter already stops on the edge that raises halt
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt <= '0;
         halt      <= 1'b0;
      end else begin
         if (halt_set) halt <= 1'b1;
         if (!halt && !halt_set) cycle_cnt <= cycle_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed self-checking bench for data_mem_mmio: RAM lanes, decode, TX FIFO, halt/counter, async reset.
module tb_data_mem_mmio;

   localparam logic [31:0] MMIO = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        data_read;
   logic [3:0]  data_write;
   logic [31:0] data_addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        halt;

   int checks = 0;
   int errors = 0;

   data_mem_mmio dut (
      .clk        (clk),
      .rst        (rst),
      .data_read  (data_read),
      .data_write (data_write),
      .data_addr  (data_addr),
      .data_in    (data_in),
      .data_out   (data_out),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .halt       (halt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b0;
      data_read  = 1'b1;
      data_write = 4'h0;
      data_addr  = 32'h0;
      data_in    = 32'h0;
      tx_ready   = 1'b0;

      #2;
      check("rst_data_out", data_out, 32'h0);
      check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      check("rst_tx_data",  {24'b0, tx_data}, 32'h0);
      check("rst_halt",     {31'b0, halt}, 32'h0);
      #10 rst = 1'b1;

      // RAM byte lanes
      data_addr = 32'h0;   data_write = 4'hF; data_in = 32'hCAFE_F00D; step();
      data_addr = 32'h100; data_write = 4'hF; data_in = 32'h1122_3344; step();
      data_write = 4'b0010; data_in = 32'hAABB_CCDD; step();
      data_write = 4'h0; step();
      check("ram_lane", data_out, 32'h1122_CC44);
      data_write = 4'hF; data_in = 32'h5566_7788; step();
      check("ram_rd_during_wr", data_out, 32'h1122_CC44);
      data_write = 4'h0; step();
      check("ram_after_wr", data_out, 32'h5566_7788);

      // unmapped write and read
      data_addr = 32'h0001_0000; data_write = 4'hF; data_in = 32'hDEAD_BEEF; step();
      data_write = 4'h0; step();
      check("unmapped_read", data_out, 32'h0);
      data_addr = 32'h0; step();
      check("ram_word0_kept", data_out, 32'hCAFE_F00D);
      data_read = 1'b0; data_addr = 32'h100; step();
      check("read_hold", data_out, 32'hCAFE_F00D);
      data_read = 1'b1;

      // FIFO fill, overflow, clear, drain
      data_addr = MMIO + 32'h4; data_write = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         data_in = 32'(8'h41 + i);
         step();
      end
      check("fifo_head", {24'b0, tx_data}, 32'h41);
      data_write = 4'h0; data_addr = MMIO + 32'h8; step();
      check("status_full", data_out, 32'h21);
      data_addr = MMIO + 32'h4; data_write = 4'b0001; data_in = 32'h45; step();
      data_write = 4'h0; data_addr = MMIO + 32'h8; step();
      check("status_ovf", data_out, 32'h25);
      data_write = 4'hF; data_in = 32'h0; step();
      data_write = 4'h0; step();
      check("status_ovf_clr", data_out, 32'h21);
      data_addr = MMIO + 32'h4; data_read = 1'b0;
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain1_valid", {31'b0, tx_valid}, 32'h1);
         check("drain1_data", {24'b0, tx_data}, 32'(8'h41 + i));
         step();
      end
      check("drain1_empty", {31'b0, tx_valid}, 32'h0);
      tx_ready = 1'b0; data_read = 1'b1;

      // push with simultaneous pop while full
      data_write = 4'b0001;
      for (int i = 1; i <= 4; i++) begin
         data_in = i;
         step();
      end
      tx_ready = 1'b1; data_in = 32'h05; step();
      tx_ready = 1'b0; data_write = 4'h0; data_addr = MMIO + 32'h8; step();
      check("status_pushpop", data_out, 32'h21);
      tx_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         check("drain2_data", {24'b0, tx_data}, i);
         step();
      end
      check("drain2_empty", {31'b0, tx_valid}, 32'h0);
      tx_ready = 1'b0;

      // cycle counter and halt
      data_addr = MMIO; data_write = 4'h0;
      rst = 1'b0; #2 rst = 1'b1;
      repeat (11) step();
      check("cycle_10", data_out, 32'd10);
      data_addr = MMIO + 32'hC; data_write = 4'hF; data_in = 32'h0; step();
      data_write = 4'h0; step();
      check("halt_zero_write", {31'b0, halt}, 32'h0);
      check("halt_read_0", data_out, 32'h0);
      data_write = 4'hF; data_in = 32'h1; step();
      check("halt_set", {31'b0, halt}, 32'h1);
      data_write = 4'h0; data_in = 32'h0; data_addr = MMIO;
      for (int i = 0; i < 5; i++) begin
         step();
         check("cycle_frozen", data_out, 32'd13);
      end

      // async reset mid-operation
      data_addr = MMIO + 32'h4; data_write = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         data_in = 32'(8'hA1 + i);
         step();
      end
      data_addr = 32'h200; data_write = 4'hF; data_in = 32'h1234_5678; step();
      data_write = 4'h0; step();
      check("pre_rst_data", data_out, 32'h1234_5678);
      check("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
      check("pre_rst_halt", {31'b0, halt}, 32'h1);
      #2 rst = 1'b0;
      #1;
      check("arst_data_out", data_out, 32'h0);
      check("arst_tx_valid", {31'b0, tx_valid}, 32'h0);
      check("arst_tx_data", {24'b0, tx_data}, 32'h0);
      check("arst_halt", {31'b0, halt}, 32'h0);
      #1 rst = 1'b1;
      data_addr = MMIO;
      step();
      check("cycle_restart_0", data_out, 32'd0);
      check("post_rst_valid", {31'b0, tx_valid}, 32'h0);
      step();
      check("cycle_restart_1", data_out, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side memory for the multi-cycle RISC-V core. It sits directly downstream of the core's data port and serves loads and stores to a word-organised RAM with byte enables. It also decodes a small MMIO window containing a cycle counter, a 4-entry console TX FIFO with a valid/ready drain port, a status register and a sticky halt flag. The testbench uses the halt flag to end simulation.

## Interface
- MEM_WORDS, 16384, RAM depth in 32-bit words (64 KiB)
- MMIO_BASE, 32'hFFFF_0000, base of the 16-byte MMIO window
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2
- clk  in  1  clock; all state changes on posedge
- rst  in  1  asynchronous, active-low reset
- data_read  in  1  read strobe; core holds it at 1
- data_write  in  4  byte-lane write enables; lane i = data_in[8i+7:8i]
- data_addr  in  32  byte address; bits [1:0] ignored
- data_in  in  32  store data
- data_out  out  32  registered read data
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  sink accepts head byte
- halt  out  1  sticky halt flag

## Operation
- Address decode uses word index w = data_addr[31:2].
  - RAM hit when data_addr < MEM_WORDS*4.
  - MMIO hit when data_addr[31:4] == MMIO_BASE[31:4].
  - Anything else is unmapped: reads return 0, writes are ignored.
- RAM write: on posedge with data_write != 0 and a RAM hit, each enabled byte lane is updated. Disabled lanes keep their value.
- RAM/MMIO read: on posedge with data_read = 1, data_out <= the selected word.
  - When data_read = 0, data_out holds its previous value.
  - Read and write to the same word in the same cycle: data_out gets the pre-write contents.
- MMIO offsets (data_addr[3:2]):
  - 0 CYCLE
    - Read: 32-bit counter.
    - Counter increments every cycle while halt = 0 and wraps FFFF_FFFF -> 0.
    - Counter freezes once halt = 1.
    - Writes are ignored.
  - 1 TXDATA
    - A write with data_write[0] = 1 pushes data_in[7:0].
    - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and ovf is set.
    - Read returns 0.
  - 2 STATUS
    - Read returns {26'b0, count[2:0], ovf, empty, full}, where count = 0..4.
    - Any write with data_write != 0 clears ovf.
  - 3 HALT
    - A write with data_write != 0 and data_in != 0 sets halt = 1.
    - Only reset clears halt.
    - Read returns {31'b0, halt}.
- TX FIFO:
  - Circular buffer with a write pointer, a read pointer and a count register. Pointers wrap modulo FIFO_DEPTH.
  - Pop occurs when tx_valid & tx_ready.
  - Push with simultaneous pop while full: accepted, count stays FIFO_DEPTH, ovf is not set.
  - Push with simultaneous pop while empty: no pop happens (tx_valid = 0), the push is stored, count = 1.
  - There is no bypass path: a pushed byte appears on tx_data/tx_valid the cycle after the push.
- Reset (rst = 0, async):
  - data_out = 0, tx_valid = 0, tx_data = 0, halt = 0.
  - Counter = 0, FIFO empty, pointers = 0, ovf = 0.
  - RAM contents are not reset; the bench preloads them.
  - If reset is asserted mid-drain, the FIFO contents are discarded.

## Timing
- Read latency is 1 cycle. Address and strobe are sampled at edge N; data_out is valid after edge N and stable until the next sampled read.
- This matches the core's data-port sequence:
  - The core sets data_addr/data_write in Execute.
  - The write commits at the Memory_Access edge.
  - Load data is consumed in Write_Back.
- Write latency: the store is visible to a read sampled on the following edge.
- tx_valid/tx_data are driven from registers. There is no combinational path from tx_ready to any output.
- halt rises on the edge after the HALT write. CYCLE stops incrementing from that same edge.
- STATUS reflects the FIFO state before the current edge's push/pop.

## Test plan
- RAM byte lanes:
  - Step 1: SW 0x11223344 to addr 0x100 with data_write = 4'hF.
  - Step 2: write 0xAABBCCDD with data_write = 4'b0010.
  - Step 3: read 0x100 -> data_out = 0x1122CC44 one cycle after the read edge.
- Unmapped / out of range: write 0xDEADBEEF to addr 0x0001_0000 (= MEM_WORDS*4) -> read of the same address returns 0, and RAM word 0 is unchanged.
- FIFO fill and overflow:
  - With tx_ready = 0, push bytes 0x41, 0x42, 0x43, 0x44 -> STATUS = 0x21 (count 4, full).
  - A 5th push of 0x45 -> dropped, STATUS = 0x25.
  - Write STATUS -> ovf cleared.
  - Raise tx_ready -> tx_data presents 0x41, 0x42, 0x43, 0x44 on consecutive cycles, then tx_valid = 0.
- Simultaneous push/pop while full:
  - Fill with 0x01..0x04, hold tx_ready = 1 and push 0x05 in the same cycle -> count stays 4, ovf = 0.
  - Drain order is 0x02, 0x03, 0x04, 0x05.
- Halt and counter:
  - Read CYCLE at reset + 10 edges -> 10.
  - Write 1 to HALT -> halt = 1 on the next edge; CYCLE reads are identical across 5 later reads.
  - Writing 0 to HALT before this -> no effect.
- Async reset mid-operation:
  - With 3 bytes queued, halt = 1 and data_out = 0x12345678, pull rst low between clock edges.
  - -> All outputs reach reset values immediately; after release, CYCLE restarts from 0 and tx_valid = 0.
